draw_sequencer: RTL

Frame-level scheduler for the shared VGA pixel path. Four pixel sources share one plot port: player, block 0, block 1 and the screen-init/clear engine. The block grants the path to one source at a time in a fixed per-frame order. It drives the `draw_select` and `draw` controls of the view multiplexer. Each frame it sequences an optional screen clear, then the player, block 0 and block 1. A watchdog keeps a stalled source from hanging the frame.

---
 rtl/draw_sequencer.sv | 74 +++++++
 1 files changed

// File: rtl/draw_sequencer.sv
// draw_sequencer: per-frame grant scheduler for the shared VGA plot path
module draw_sequencer #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter bit CLEAR_FIRST = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       init_req,
  input  logic       init_valid,
  input  logic       init_last,
  input  logic       p_valid,
  input  logic       p_last,
  input  logic       b0_valid,
  input  logic       b0_last,
  input  logic       b1_valid,
  input  logic       b1_last,
  output logic [1:0] draw_select,
  output logic       draw,
  output logic [3:0] grant,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun,
  output logic       timeout
);
  typedef enum logic [2:0] {IDLE, INIT, PLAYER, BLK0, BLK1, DONE} state_t;
  state_t state;
  logic init_pending, frame_active, g_valid, g_last, advance, pend;
  logic [15:0] wd;
  localparam logic [15:0] WD_MAX = 16'(TIMEOUT_CYCLES - 1);
  // decode the granted source and the view-mux controls straight from state
  always_comb begin
    grant = {state == INIT, state == BLK1, state == BLK0, state == PLAYER};
    draw_select = grant[3] ? 2'b11 : grant[2] ? 2'b10 : grant[1] ? 2'b01 : 2'b00;
    g_valid = |(grant & {init_valid, b1_valid, b0_valid, p_valid});
    g_last = |(grant & {init_last, b1_last, b0_last, p_last});
    draw = g_valid;
    busy = state != IDLE;
    frame_done = state == DONE;
    overrun = frame_start && state != IDLE;
    timeout = |grant && !g_valid && wd == WD_MAX;
    advance = |grant && ((g_valid && g_last) || timeout);
    pend = init_pending || init_req;
  end
  // frame sequencing, pending-clear bookkeeping and stall watchdog
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      init_pending <= CLEAR_FIRST;
      frame_active <= 1'b0;
      wd <= '0;
    end else begin
      init_pending <= state != IDLE && pend;
      wd <= (advance || !(|grant) || g_valid) ? '0 : wd + 16'd1;
      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= pend ? INIT : PLAYER;
            frame_active <= 1'b1;
          end else if (pend) state <= INIT;
        end
        INIT: if (advance) state <= frame_active ? PLAYER : IDLE;
        PLAYER: if (advance) state <= BLK0;
        BLK0: if (advance) state <= BLK1;
        BLK1: if (advance) state <= DONE;
        DONE: begin
          state <= IDLE;
          frame_active <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
